// File: rtl/fft_peak_detector.sv
// fft_peak_detector: unloads one FFT frame, finds the bin with the largest
// magnitude (re^2 + im^2 on the upper MAG_BITS of each component), and
// optionally sums all bin magnitudes.
// Optional feature macro: FFT_PEAK_SUM_EN enables the SUM_MAG accumulator.
// Without it, SUM_MAG is tied to zero.
// Pipeline: stage 1 truncates the sample, stage 2 squares and adds,
// stage 3 compares and accumulates. DRAIN covers stages 2/3 after the last
// sample, so PEAK_VALID lands 3 cycles after the last accepted sample.
module fft_peak_detector #(
  parameter int POINTS   = 1024,
  parameter int IDX_W    = 10,
  parameter int MAG_BITS = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ARM,
  input  logic                        OUTP_READY,
  input  logic                        DATAO_VALID,
  input  logic [31:0]                 DATAO_RE,
  input  logic [31:0]                 DATAO_IM,
  output logic                        READ_OUTP,
  output logic                        PEAK_VALID,
  output logic [IDX_W-1:0]            PEAK_IDX,
  output logic [2*MAG_BITS:0]         PEAK_MAG,
  output logic [2*MAG_BITS+IDX_W:0]   SUM_MAG,
  output logic                        BUSY
);

  localparam int MAG_W  = 2*MAG_BITS + 1;
  localparam int SUM_W  = MAG_W + IDX_W;
  localparam int SQ_W   = 2*MAG_BITS;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                     state;
  logic [IDX_W-1:0]           cnt;
  logic                       drain_cnt;
  logic                       accept;
  logic                       last;

  // pipeline valid bits: [0] = stage 1 holds a sample, [1] = stage 2 holds a magnitude
  logic [STAGES-1:0]          vld_pipe;

  logic signed [MAG_BITS-1:0] re_t, im_t;
  logic [IDX_W-1:0]           s1_idx;
  logic signed [SQ_W-1:0]     re_x, im_x, re_sq, im_sq;
  logic [MAG_W-1:0]           mag_c;
  logic [MAG_W-1:0]           s2_mag;
  logic [IDX_W-1:0]           s2_idx;

  logic                       first;
  logic                       take;
  logic [MAG_W-1:0]           best_mag, best_mag_nxt;
  logic [IDX_W-1:0]           best_idx, best_idx_nxt;
  logic                       publish;

  // low component bits never reach the magnitude
  logic                       unused_lsbs;
  assign unused_lsbs = ^{DATAO_RE[31-MAG_BITS:0], DATAO_IM[31-MAG_BITS:0]};

  assign accept  = (state == COLLECT) && DATAO_VALID;
  assign last    = accept && (cnt == IDX_W'(POINTS - 1));
  // second DRAIN cycle: stage 3 is absorbing the final sample right now
  assign publish = (state == DRAIN) && drain_cnt;

  // control FSM: frame handshake, sample counting, drain timing, result pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      drain_cnt  <= 1'b0;
      READ_OUTP  <= 1'b0;
      BUSY       <= 1'b0;
      PEAK_VALID <= 1'b0;
    end else begin
      PEAK_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (ARM && OUTP_READY) begin
            state     <= COLLECT;
            cnt       <= '0;
            READ_OUTP <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (last) begin
              state     <= DRAIN;
              cnt       <= '0;
              drain_cnt <= 1'b0;
              READ_OUTP <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state      <= DONE;
            drain_cnt  <= 1'b0;
            PEAK_VALID <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          READ_OUTP <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  // valid shift register; cleared on reset so a partial frame never publishes
  always_ff @(posedge CLK) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[0], accept};
  end

  // stage 1: keep the signed upper bits of each component plus the bin index
  always_ff @(posedge CLK) begin
    re_t   <= DATAO_RE[31 -: MAG_BITS];
    im_t   <= DATAO_IM[31 -: MAG_BITS];
    s1_idx <= cnt;
  end

  // squares are non-negative and at most 2^(2*MAG_BITS-2), so they fit SQ_W
  // bits; their sum needs one more bit and can never saturate
  assign re_x  = {{MAG_BITS{re_t[MAG_BITS-1]}}, re_t};
  assign im_x  = {{MAG_BITS{im_t[MAG_BITS-1]}}, im_t};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag_c = {1'b0, re_sq} + {1'b0, im_sq};

  // stage 2: register the magnitude with its bin index
  always_ff @(posedge CLK) begin
    s2_mag <= mag_c;
    s2_idx <= s1_idx;
  end

  // stage 3 compare: bin 0 reloads the peak; strict > keeps the lowest index on ties
  always_comb begin
    first        = (s2_idx == '0);
    take         = vld_pipe[1] && (first || (s2_mag > best_mag));
    best_mag_nxt = best_mag;
    best_idx_nxt = best_idx;
    if (take) begin
      best_mag_nxt = s2_mag;
      best_idx_nxt = s2_idx;
    end
  end

  // stage 3 running peak
  always_ff @(posedge CLK) begin
    if (RST) begin
      best_mag <= '0;
      best_idx <= '0;
    end else begin
      best_mag <= best_mag_nxt;
      best_idx <= best_idx_nxt;
    end
  end

  // published peak, held until the next frame completes
  always_ff @(posedge CLK) begin
    if (RST) begin
      PEAK_IDX <= '0;
      PEAK_MAG <= '0;
    end else if (publish) begin
      PEAK_IDX <= best_idx_nxt;
      PEAK_MAG <= best_mag_nxt;
    end
  end

`ifdef FFT_PEAK_SUM_EN
  // POINTS * max magnitude fits in MAG_W + IDX_W bits, so no overflow
  logic [SUM_W-1:0] sum_acc, sum_nxt;

  // stage 3 sum: bin 0 restarts the total
  always_comb begin
    sum_nxt = sum_acc;
    if (vld_pipe[1]) begin
      if (first) sum_nxt = SUM_W'(s2_mag);
      else       sum_nxt = sum_acc + SUM_W'(s2_mag);
    end
  end

  // running sum register
  always_ff @(posedge CLK) begin
    if (RST) sum_acc <= '0;
    else     sum_acc <= sum_nxt;
  end

  // published sum, held with the peak
  always_ff @(posedge CLK) begin
    if (RST)          SUM_MAG <= '0;
    else if (publish) SUM_MAG <= sum_nxt;
  end
`else
  assign SUM_MAG = '0;
`endif

endmodule

// File: tb/tb_fft_peak_detector.sv
// tb_fft_peak_detector: randomized and directed frames against a frame-level
// reference model (timing expressed as cycles since the last accepted sample,
// results from a plain max/sum over the collected magnitudes).
module tb_fft_peak_detector;

  localparam int POINTS   = 1024;
  localparam int IDX_W    = 10;
  localparam int MAG_BITS = 16;

`ifdef FFT_PEAK_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic                      clk;
  logic                      rst;
  logic                      arm;
  logic                      outp_ready;
  logic                      datao_valid;
  logic [31:0]               datao_re;
  logic [31:0]               datao_im;
  logic                      read_outp;
  logic                      peak_valid;
  logic [IDX_W-1:0]          peak_idx;
  logic [2*MAG_BITS:0]       peak_mag;
  logic [2*MAG_BITS+IDX_W:0] sum_mag;
  logic                      busy;

  fft_peak_detector #(.POINTS(POINTS), .IDX_W(IDX_W), .MAG_BITS(MAG_BITS)) dut (
    .CLK(clk), .RST(rst), .ARM(arm), .OUTP_READY(outp_ready),
    .DATAO_VALID(datao_valid), .DATAO_RE(datao_re), .DATAO_IM(datao_im),
    .READ_OUTP(read_outp), .PEAK_VALID(peak_valid), .PEAK_IDX(peak_idx),
    .PEAK_MAG(peak_mag), .SUM_MAG(sum_mag), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int pv_count = 0;
  int start_wait, done_wait;

  logic [31:0] fre [POINTS];
  logic [31:0] fim [POINTS];

  // reference model state
  bit     m_coll = 1'b0;
  int     m_after = 0;      // cycles since last accepted sample, 0 = none pending
  longint m_idx = 0, m_mag = 0, m_sum = 0;
  longint mags [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint mag_of(input logic [31:0] re, input logic [31:0] im);
    longint r, i;
    r = longint'($signed(re)) >>> (32 - MAG_BITS);
    i = longint'($signed(im)) >>> (32 - MAG_BITS);
    return r*r + i*i;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'h0000_0000;
      3:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // compare DUT against the model every cycle, then advance the model
  initial forever begin
    @(negedge clk);
    chk("read_outp", {63'd0, read_outp}, {63'd0, m_coll});
    chk("busy", {63'd0, busy}, {63'd0, (m_coll || m_after != 0)});
    chk("peak_valid", {63'd0, peak_valid}, {63'd0, (m_after == 3)});
    chk("peak_idx", 64'(peak_idx), 64'(m_idx));
    chk("peak_mag", 64'(peak_mag), 64'(m_mag));
    chk("sum_mag", 64'(sum_mag), SUM_ON ? 64'(m_sum) : 64'd0);
    if (read_outp) rd_cycles++;
    if (peak_valid) pv_count++;
    if (rst) begin
      m_coll = 1'b0; m_after = 0; m_idx = 0; m_mag = 0; m_sum = 0;
      mags.delete();
    end else if (m_coll) begin
      if (datao_valid) begin
        mags.push_back(mag_of(datao_re, datao_im));
        if (mags.size() == POINTS) begin
          m_coll = 1'b0;
          m_after = 1;
        end
      end
    end else if (m_after != 0) begin
      if (m_after == 2) begin
        m_idx = 0; m_mag = mags[0]; m_sum = 0;
        foreach (mags[j]) begin
          m_sum += mags[j];
          if (mags[j] > m_mag) begin
            m_mag = mags[j];
            m_idx = j;
          end
        end
      end
      m_after = (m_after == 3) ? 0 : m_after + 1;
    end else if (arm && outp_ready) begin
      m_coll = 1'b1;
      mags.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    datao_valid = 1'($urandom_range(0, 1));
    datao_re    = $urandom;
    datao_im    = $urandom;
  endtask

  task automatic clear_frame();
    for (int j = 0; j < POINTS; j++) begin
      fre[j] = 32'd0;
      fim[j] = 32'd0;
    end
  endtask

  task automatic rand_frame();
    for (int j = 0; j < POINTS; j++) begin
      fre[j] = rnd_val();
      fim[j] = rnd_val();
    end
  endtask

  // gap_mode: 0 contiguous, 1 every other cycle, 2 random gaps
  task automatic run_frame(input int gap_mode, input int arm_delay, input int abort_at, input bit drop_arm);
    int  i, ph, k;
    bit  v;
    rd_cycles  = 0;
    outp_ready = 1'b1;
    arm        = (arm_delay == 0);
    for (int d = 0; d < arm_delay; d++) begin
      junk();
      tick();
    end
    if (arm_delay > 0) chk("arm_gate_read", {63'd0, read_outp}, 64'd0);
    arm = 1'b1;
    k = 0;
    while (!read_outp && k < 50) begin
      junk();
      tick();
      k++;
    end
    start_wait = k;
    if (!read_outp) begin
      chk("start_timeout", {63'd0, read_outp}, 64'd1);
      return;
    end
    i = 0; ph = 0;
    while (i < POINTS && ph < 20*POINTS) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (ph % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (v) begin
        datao_valid = 1'b1;
        datao_re    = fre[i];
        datao_im    = fim[i];
      end else begin
        datao_valid = 1'b0;
        datao_re    = $urandom;
        datao_im    = $urandom;
      end
      if (drop_arm && i == 10) arm = 1'b0;
      tick();
      ph++;
      if (v) i++;
      if (abort_at >= 0 && i == abort_at) begin
        rst = 1'b1;
        datao_valid = 1'b0;
        tick();
        rst = 1'b0;
        return;
      end
    end
    junk();
    k = 0;
    while (!peak_valid && k < 20) begin
      junk();
      tick();
      k++;
    end
    done_wait = k;
    chk("done_timeout", {63'd0, peak_valid}, 64'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv0;
    rst = 1'b1; arm = 1'b0; outp_ready = 1'b0; datao_valid = 1'b0;
    datao_re = 32'd0; datao_im = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_read", {63'd0, read_outp}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pv", {63'd0, peak_valid}, 64'd0);
    chk("rst_idx", 64'(peak_idx), 64'd0);
    chk("rst_mag", 64'(peak_mag), 64'd0);
    chk("rst_sum", 64'(sum_mag), 64'd0);

    // single tone, with 50 cycles of OUTP_READY=1/ARM=0 first
    clear_frame();
    fre[37] = 32'h4000_0000;
    run_frame(0, 50, -1, 1'b0);
    chk("arm_rise_latency", 64'(start_wait), 64'd1);
    chk("tone_latency", 64'(done_wait), 64'd2);
    chk("tone_idx", 64'(peak_idx), 64'd37);
    chk("tone_mag", 64'(peak_mag), 64'h1000_0000);
    chk("tone_sum", 64'(sum_mag), SUM_ON ? 64'h1000_0000 : 64'd0);
    chk("tone_model_mag", 64'(m_mag), 64'h1000_0000);

    // tie between bins 100 and 900; ARM dropped mid-frame
    clear_frame();
    fre[100] = 32'h0001_0000; fim[100] = 32'h0001_0000;
    fre[900] = 32'h0001_0000; fim[900] = 32'h0001_0000;
    run_frame(0, 0, -1, 1'b1);
    chk("tie_idx", 64'(peak_idx), 64'd100);
    chk("tie_mag", 64'(peak_mag), 64'd2);
    chk("tie_sum", 64'(sum_mag), SUM_ON ? 64'd4 : 64'd0);
    chk("tie_model_idx", 64'(m_idx), 64'd100);

    // most-negative components
    clear_frame();
    fre[5] = 32'h8000_0000; fim[5] = 32'h8000_0000;
    run_frame(0, 0, -1, 1'b0);
    chk("neg_idx", 64'(peak_idx), 64'd5);
    chk("neg_mag", 64'(peak_mag), 64'h8000_0000);

    // stalled stream: valid every other cycle
    clear_frame();
    fre[37] = 32'h4000_0000;
    run_frame(1, 0, -1, 1'b0);
    chk("stall_read_cycles", 64'(rd_cycles), 64'd2047);
    chk("stall_idx", 64'(peak_idx), 64'd37);
    chk("stall_mag", 64'(peak_mag), 64'h1000_0000);

    // ARM high but no frame available
    arm = 1'b1;
    outp_ready = 1'b0;
    for (int d = 0; d < 20; d++) begin
      junk();
      tick();
    end
    chk("ready_gate_read", {63'd0, read_outp}, 64'd0);

    // reset after 500 samples, then a full random frame
    pv0 = pv_count;
    rand_frame();
    run_frame(2, 0, 500, 1'b0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_mag_cleared", 64'(peak_mag), 64'd0);
    rand_frame();
    run_frame(2, 0, -1, 1'b0);
    chk("abort_pulses", 64'(pv_count - pv0), 64'd1);

    // randomized back-to-back frames
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      run_frame(2, 0, -1, (f == 1));
    end

    arm = 1'b0;
    for (int d = 0; d < 5; d++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
